sbox_layer_driver: RTL and testbench
====================================

SBOX_LAYER_DRIVER -- requirements
Module: sbox_layer_driver

Interface
REQ-001 The block SHALL have one parameter line, NIBBLES, default 32: the number of 4-bit nibbles per share, so the state is 4*NIBBLES bits.
REQ-002 The ports SHALL be as follows, one per line:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin one S-box layer; sampled only in IDLE.
- share0_in, share1_in  in  4*NIBBLES  input state shares, captured on the start edge.
- seed_load  in  1  load seed into the guard LFSR; honoured only in IDLE.
- seed  in  32  LFSR seed value.
- sb_in0, sb_in1  out  4  nibble shares to the shared S-box, bit order {d,c,b,a}.
- sb_guards  out  10  fresh guard bits to the shared S-box.
- sb_out0, sb_out1  in  4  shared S-box output shares; registered 1-cycle latency.
- share0_out, share1_out  out  4*NIBBLES  substituted state shares.
- busy  out  1  high in FEED and DRAIN.
- done  out  1  one-cycle pulse when share*_out is updated.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, FEED and DRAIN.
REQ-004 In IDLE, start=1 SHALL capture share0_in/share1_in into internal shift registers, clear the nibble counter and enter FEED at the same edge.
REQ-005 FEED SHALL last exactly NIBBLES cycles; in cycle k, sb_in0 and sb_in1 SHALL carry nibble k of share0 and share1 respectively, where nibble 0 is bits [3:0].
REQ-006 The S-box result for nibble k SHALL be sampled from sb_out0/sb_out1 at the edge ending cycle k+1, then stored as nibble k of the share0/share1 result.
REQ-007 After the last FEED cycle the FSM SHALL spend exactly one DRAIN cycle, which captures nibble NIBBLES-1, then return to IDLE.
REQ-008 share0_out/share1_out SHALL update only at the DRAIN exit edge, all nibbles together, and SHALL hold their value otherwise.
REQ-009 done SHALL be high for exactly the one cycle after the DRAIN exit edge, i.e. NIBBLES+1 cycles after the start edge (33 for the default).
REQ-010 The block SHALL ignore start while busy=1.
REQ-011 start asserted during the done cycle SHALL be accepted, since the FSM is already in IDLE then.
REQ-012 Outside FEED, sb_in0, sb_in1 and sb_guards SHALL be driven to 0.
REQ-013 The guard LFSR SHALL be a 32-bit Fibonacci register s; one step is fb = s[31]^s[21]^s[1]^s[0], then s <= {s[30:0], fb}.
REQ-014 During FEED, sb_guards SHALL equal s[9:0] and s SHALL advance 10 steps per cycle, so each guard bit is used once.
REQ-015 Outside FEED, s SHALL hold its value.
REQ-016 seed_load in IDLE SHALL set s to seed, or to 32'h0000_0001 if seed is 0.
REQ-017 seed_load while busy SHALL be ignored.
REQ-018 If seed_load and start are asserted in the same IDLE cycle, both SHALL take effect, and FEED cycle 0 SHALL use the new seed.
REQ-019 The block SHALL NOT recombine shares: share0 and share1 data paths never meet in one gate.

Reset
REQ-020 While rst_n=0, asynchronously and regardless of clk:
- state = IDLE, counter = 0;
- s = 32'h0000_0001;
- share0_out, share1_out, internal shift registers = 0;
- sb_in0, sb_in1, sb_guards = 0;
- busy = 0, done = 0.
REQ-021 A reset asserted during FEED or DRAIN SHALL abort the layer with no done pulse, and a start after reset release SHALL run normally.

Verification
REQ-022 The bench SHALL cover these directed scenarios. The S-box stub is registered with 1-cycle latency: out0 <= in0 ^ 4'hA, out1 <= in1.
- Reset: apply rst_n=0 mid-cycle with no clk edge -> all outputs 0 and busy=0 at once.
- One layer: share0_in = {8{32'h0123_4567}}, share1_in = {32{4'hF}}, start for one cycle -> busy high for 33 cycles, done high in cycle 33 only, share0_out = {8{32'hAB89_EFCD}}, share1_out = {32{4'hF}}.
- Busy/back-to-back: start pulses during FEED are ignored (exactly one done); start during the done cycle -> busy next cycle, second done 33 cycles later.
- Seed: seed_load with seed = 0, then start -> sb_guards = 10'h001 in FEED cycle 0 and 10'h2DB in cycle 1; sb_guards = 0 in IDLE.
- Mid-layer reset: rst_n low in FEED cycle 10 -> no done, outputs 0; a new start then completes with correct results.
- Guards: across a 32-cycle FEED, sb_guards matches a reference LFSR model stepped 10 times per cycle, and s is unchanged across the IDLE gap.

Source files
------------

// File: rtl/sbox_layer_driver.sv
// Streams a two-share state through one shared, registered S-box, one nibble per cycle,
// supplying 10 fresh LFSR guard bits per nibble and reassembling the substituted shares.
module sbox_layer_driver #(
  parameter int NIBBLES = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   share0_in,
  input  logic [4*NIBBLES-1:0]   share1_in,
  input  logic                   seed_load,
  input  logic [31:0]            seed,
  output logic [3:0]             sb_in0,
  output logic [3:0]             sb_in1,
  output logic [9:0]             sb_guards,
  input  logic [3:0]             sb_out0,
  input  logic [3:0]             sb_out1,
  output logic [4*NIBBLES-1:0]   share0_out,
  output logic [4*NIBBLES-1:0]   share1_out,
  output logic                   busy,
  output logic                   done
);
  localparam int W  = 4*NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES-1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [W-1:0]  src0, src1, res0, res1;
  logic [31:0]   s;
  logic          feed;

  function automatic logic [31:0] lfsr_step10(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 10; i++) r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    return r;
  endfunction

  // Results arrive one cycle late, so new nibbles enter at the top and slide down.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] r, input logic [3:0] nib);
    return (r >> 4) | ({{(W-4){1'b0}}, nib} << (W-4));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FEED;
      FEED:    if (cnt == LAST) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    feed      = (state == FEED);
    busy      = (state != IDLE);
    sb_in0    = feed ? src0[3:0] : 4'h0;
    sb_in1    = feed ? src1[3:0] : 4'h0;
    sb_guards = feed ? s[9:0]    : 10'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == DRAIN);
      if (state == IDLE && start) cnt <= '0;
      else if (feed)              cnt <= cnt + 1'b1;
    end
  end

  // Share 0 path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src0 <= '0;
      res0 <= '0;
      share0_out <= '0;
    end else begin
      if (state == IDLE && start) src0 <= share0_in;
      else if (feed)              src0 <= src0 >> 4;
      if (feed && cnt != '0) res0 <= shift_in(res0, sb_out0);
      if (state == DRAIN)    share0_out <= shift_in(res0, sb_out0);
    end
  end

  // Share 1 path, kept fully separate from share 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src1 <= '0;
      res1 <= '0;
      share1_out <= '0;
    end else begin
      if (state == IDLE && start) src1 <= share1_in;
      else if (feed)              src1 <= src1 >> 4;
      if (feed && cnt != '0) res1 <= shift_in(res1, sb_out1);
      if (state == DRAIN)    share1_out <= shift_in(res1, sb_out1);
    end
  end

  // A zero seed would lock the LFSR, so it is replaced by 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       s <= 32'h0000_0001;
    else if (state == IDLE && seed_load) s <= (seed == 32'h0) ? 32'h0000_0001 : seed;
    else if (feed)                    s <= lfsr_step10(s);
  end
endmodule

// File: tb/tb_sbox_layer_driver.sv
// Directed bench: registered S-box stub, layer results, busy/back-to-back, seeding, mid-layer reset.
module tb_sbox_layer_driver;
  logic         clk, rst_n, start, seed_load;
  logic [127:0] share0_in, share1_in, share0_out, share1_out;
  logic [31:0]  seed;
  logic [3:0]   sb_in0, sb_in1, sb_out0, sb_out1;
  logic [9:0]   sb_guards;
  logic         busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0]  gref;
  logic [9:0]   g0, g1;

  sbox_layer_driver #(.NIBBLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .share0_in(share0_in), .share1_in(share1_in),
    .seed_load(seed_load), .seed(seed),
    .sb_in0(sb_in0), .sb_in1(sb_in1), .sb_guards(sb_guards),
    .sb_out0(sb_out0), .sb_out1(sb_out1),
    .share0_out(share0_out), .share1_out(share1_out),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered S-box stub
  always_ff @(posedge clk) begin
    sb_out0 <= sb_in0 ^ 4'hA;
    sb_out1 <= sb_in1;
  end

  function automatic logic [31:0] ref_step10(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 10; i++) r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller has driven start=1 and the shares at a negedge; returns at the done cycle.
  task automatic run_layer(input logic [127:0] in0, input logic [127:0] in1, input bit noise);
    int n;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0; n = 1;
    while (done !== 1'b1 && n < 100) begin
      check("busy_in_layer", busy, 1);
      if (n <= 32) begin
        check("sb_in0", sb_in0, in0[4*(n-1) +: 4]);
        check("sb_in1", sb_in1, in1[4*(n-1) +: 4]);
        check("guards_feed", sb_guards, gref[9:0]);
        if (n == 1) g0 = sb_guards;
        if (n == 2) g1 = sb_guards;
        gref = ref_step10(gref);
      end else begin
        check("guards_drain", sb_guards, 0);
      end
      if (noise) begin
        start = (n % 5 == 2) || (n == 33);
        seed_load = (n % 7 == 4) || (n == 33);
        seed = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      start = 1'b0; seed_load = 1'b0; n++;
    end
    check("done_latency", n, 34);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; seed_load = 1'b0; seed = 32'h0;
    share0_in = '0; share1_in = '0;

    // Asynchronous reset with no clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sb_in", {sb_in0, sb_in1, sb_guards}, 0);
    check("rst_share0_out", share0_out, 0);
    check("rst_share1_out", share1_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gref = 32'h1;
    @(negedge clk);

    // One layer with start/seed_load noise while busy, then start in the done cycle
    share0_in = {8{32'h0123_4567}}; share1_in = {32{4'hF}}; start = 1'b1;
    run_layer({8{32'h0123_4567}}, {32{4'hF}}, 1'b1);
    check("layer1_share0", share0_out, {8{32'hAB89_EFCD}});
    check("layer1_share1", share1_out, {32{4'hF}});
    share0_in = {32{4'h5}}; share1_in = {16{8'h3C}}; start = 1'b1;
    run_layer({32{4'h5}}, {16{8'h3C}}, 1'b0);
    check("b2b_share0", share0_out, {32{4'hF}});
    check("b2b_share1", share1_out, {16{8'h3C}});
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("guards_idle", sb_guards, 0);

    // Seed 0 loaded together with start
    share0_in = {8{32'h0123_4567}}; share1_in = {32{4'hF}};
    seed = 32'h0; seed_load = 1'b1; start = 1'b1;
    gref = 32'h1;
    run_layer({8{32'h0123_4567}}, {32{4'hF}}, 1'b0);
    check("seed0_guard_c0", g0, 10'h001);
    check("seed0_guard_c1", g1, 10'h2DB);
    check("seed_layer_share0", share0_out, {8{32'hAB89_EFCD}});

    // LFSR holds through an idle gap; guards continue from the model
    repeat (5) begin
      @(negedge clk);
      check("guards_gap", sb_guards, 0);
    end
    share0_in = {4{32'h89AB_CDEF}}; share1_in = {4{32'h1357_9BDF}}; start = 1'b1;
    run_layer({4{32'h89AB_CDEF}}, {4{32'h1357_9BDF}}, 1'b0);
    check("gap_share0", share0_out, {4{32'h2301_6745}});
    check("gap_share1", share1_out, {4{32'h1357_9BDF}});

    // Reset during FEED cycle 10
    @(negedge clk);
    share0_in = {32{4'h5}}; share1_in = {16{8'h3C}}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_sb", {sb_in0, sb_in1, sb_guards}, 0);
    check("midrst_share0_out", share0_out, 0);
    check("midrst_share1_out", share1_out, 0);
    repeat (40) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    rst_n = 1'b1;
    gref = 32'h1;
    @(negedge clk);
    share0_in = {4{32'h89AB_CDEF}}; share1_in = {4{32'h1357_9BDF}}; start = 1'b1;
    run_layer({4{32'h89AB_CDEF}}, {4{32'h1357_9BDF}}, 1'b0);
    check("post_rst_share0", share0_out, {4{32'h2301_6745}});
    check("post_rst_share1", share1_out, {4{32'h1357_9BDF}});
    @(negedge clk);
    check("post_rst_done_clear", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
